// File: rtl/ldtu_dtu_word_rx.sv
// DTU word receiver: idle-word lock, idle drop, 16-deep Hamming(38,32) buffer with
// single-error correction on read, and a registered valid/ready output stage.
module ldtu_dtu_word_rx #(
  parameter int          Nbits_32       = 32,
  parameter int          Nbits_ham      = 38,
  parameter int          FifoDepth      = 16,
  parameter int          bits_ptr       = 4,
  parameter logic [31:0] idle_patternEA = 32'hEAAAAAAA,
  parameter int          IdleLockCount  = 4
) (
  input  logic                 CLK,
  input  logic                 rst_b,
  input  logic                 word_valid,
  input  logic [Nbits_32-1:0]  word_in,
  input  logic [Nbits_ham-1:0] inj_mask,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [Nbits_32-1:0]  out_data,
  output logic                 sec_error,
  output logic                 unc_error,
  output logic                 locked,
  output logic                 overflow,
  output logic [bits_ptr:0]    fill_level,
  output logic [15:0]          idle_count
);

  localparam int SynW = $clog2(Nbits_ham + 1);
  localparam int RunW = $clog2(IdleLockCount + 1);

  typedef enum logic {S_UNLOCKED, S_LOCKED} state_t;

  typedef struct packed {
    logic [Nbits_32-1:0] data;
    logic                sec;
    logic                unc;
  } dec_t;

  // Data bits occupy the non-power-of-two positions in ascending order.
  function automatic logic [Nbits_ham-1:0] f_encode(input logic [Nbits_32-1:0] d);
    logic [Nbits_ham-1:0] cw;
    logic                 par;
    int                   k;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= Nbits_ham; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    for (int i = 0; i < SynW; i++) begin
      par = 1'b0;
      for (int p = 1; p <= Nbits_ham; p++)
        if (((p >> i) & 1) == 1) par ^= cw[p-1];
      cw[(1 << i) - 1] = par;
    end
    return cw;
  endfunction

  function automatic dec_t f_decode(input logic [Nbits_ham-1:0] cw_in);
    dec_t                 r;
    logic [Nbits_ham-1:0] cw;
    logic [SynW-1:0]      syn;
    int                   k;
    cw  = cw_in;
    syn = '0;
    r   = '0;
    for (int p = 1; p <= Nbits_ham; p++)
      if (cw[p-1]) syn ^= SynW'(p);
    if (syn != '0 && int'(syn) <= Nbits_ham) begin
      cw[syn - SynW'(1)] = ~cw[syn - SynW'(1)];
      r.sec = 1'b1;
    end else if (int'(syn) > Nbits_ham) begin
      r.unc = 1'b1;
    end
    k = 0;
    for (int p = 1; p <= Nbits_ham; p++)
      if ((p & (p - 1)) != 0) begin
        r.data[k] = cw[p-1];
        k++;
      end
    return r;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [RunW-1:0]      r_run;
  logic [15:0]          r_idle_cnt;
  logic [Nbits_ham-1:0] r_mem [FifoDepth];
  logic [bits_ptr-1:0]  r_wptr, r_rptr;
  logic [bits_ptr:0]    r_count;
  logic                 r_ovf;
  logic                 r_out_valid;
  dec_t                 r_out;

  logic w_is_idle, w_push_req, w_push, w_pop;
  dec_t w_dec;

  assign w_is_idle  = (word_in == idle_patternEA);
  assign w_push_req = word_valid && (r_state == S_LOCKED) && !w_is_idle;
  assign w_pop      = (!r_out_valid || out_ready) && (r_count != '0);
  // A full buffer still accepts when the head leaves on the same edge.
  assign w_push     = w_push_req && ((r_count < (bits_ptr+1)'(FifoDepth)) || w_pop);
  assign w_dec      = f_decode(r_mem[r_rptr]);

  always_comb begin
    w_state_nxt = r_state;
    if (word_valid && r_state == S_UNLOCKED && w_is_idle &&
        r_run == RunW'(IdleLockCount - 1))
      w_state_nxt = S_LOCKED;
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) r_state <= S_UNLOCKED;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_run      <= '0;
      r_idle_cnt <= '0;
    end else if (word_valid) begin
      if (r_state == S_UNLOCKED) begin
        if (!w_is_idle || w_state_nxt == S_LOCKED) r_run <= '0;
        else                                      r_run <= r_run + RunW'(1);
      end else if (w_is_idle && r_idle_cnt != 16'hFFFF) begin
        r_idle_cnt <= r_idle_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= f_encode(word_in) ^ inj_mask;
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + bits_ptr'(1);
      if (w_pop)  r_rptr <= r_rptr + bits_ptr'(1);
      r_count <= r_count + (bits_ptr+1)'(w_push) - (bits_ptr+1)'(w_pop);
      if (w_push_req && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out       <= w_dec;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out.data;
  assign sec_error  = r_out.sec;
  assign unc_error  = r_out.unc;
  assign locked     = (r_state == S_LOCKED);
  assign overflow   = r_ovf;
  assign fill_level = r_count;
  assign idle_count = r_idle_cnt;

endmodule
